vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 24, 136, 160, giving horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 768, visible lines.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 3, 6, 29, giving vertical porch and sync in lines.
REQ-005 SHALL have parameters HS_POL and VS_POL, default 0, giving the sync active level (0 = active-low).
REQ-006 SHALL derive XW = clog2(H_TOTAL) and YW = clog2(V_TOTAL) as localparams, where H_TOTAL and V_TOTAL are the sums of the four segments.
REQ-007 SHALL have port clk, input, 1 bit, the single clock.
REQ-008 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-009 SHALL have port pix_en, input, 1 bit, the pixel-advance enable (divided pixel clocks).
REQ-010 SHALL have port irq_clr, input, 1 bit, which clears frame_irq and line_irq.
REQ-011 SHALL have port line_cmp, input, YW bits, the raster line at which line_irq fires.
REQ-012 SHALL have ports x and y, outputs, XW and YW bits, the current counters.
REQ-013 SHALL have ports hsync, vsync and blank, outputs, 1 bit each, all registered.
REQ-014 SHALL have ports frame_irq and line_irq, outputs, 1 bit each, sticky.
REQ-015 SHALL have port frame_cnt, output, 8 bits, the frame counter.

Function
REQ-016 SHALL hold all state in every cycle where pix_en=0, except that interrupt clearing still applies.
REQ-017 SHALL, when pix_en=1, advance x as x+1, and wrap x from H_TOTAL-1 to 0.
REQ-018 SHALL advance y only on the x wrap, and wrap y from V_TOTAL-1 to 0.
REQ-019 SHALL increment frame_cnt (mod 256) on the y wrap.
REQ-020 SHALL register hsync, vsync and blank from the current x/y, so they are valid one enabled cycle after the x/y they describe.
REQ-021 SHALL drive hsync to HS_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, and to !HS_POL otherwise.
REQ-022 SHALL drive vsync to VS_POL iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, and to !VS_POL otherwise.
REQ-023 SHALL drive blank to 1 iff x >= H_ACTIVE or y >= V_ACTIVE.
REQ-024 SHALL set frame_irq on the clock edge where x and y both wrap to 0.
REQ-025 SHALL set line_irq on the clock edge where x wraps to 0 and the new y equals line_cmp.
REQ-026 SHALL keep line_irq at 0 when line_cmp >= V_TOTAL.
REQ-027 SHALL clear both interrupts on irq_clr=1; a set event in the same cycle wins.
REQ-028 SHALL sample line_cmp only at the x wrap, so a change mid-line takes effect at the next line boundary.
REQ-029 SHALL flag a parameter error at elaboration if any segment parameter is 0.

Reset
REQ-030 SHALL, on rst=1 at a clk edge, set x=0, y=0, frame_cnt=0, frame_irq=0, line_irq=0, blank=0, hsync=!HS_POL and vsync=!VS_POL.
REQ-031 SHALL give rst priority over pix_en and irq_clr, including reset asserted mid-line or mid-sync.
REQ-032 SHALL, on the first enabled cycle after reset, drive outputs that describe (0,0).

Configuration
REQ-033 SHALL, with macro VGA_TIMING_LINE_IRQ_EN defined, implement line_cmp and line_irq as in REQ-025 to REQ-028.
REQ-034 SHALL, without VGA_TIMING_LINE_IRQ_EN, keep the line_cmp port but ignore it, tie line_irq to 0, and omit the compare logic.

Structure
REQ-035 SHALL place the default timing constants (1024x768), a clog2 function and the sync polarity constants in package vga_timing_pkg.
REQ-036 SHALL use one sub-module, vga_axis_counter: a parametrised wrap counter with enable, wrap pulse and segment-range compare, instantiated once for x and once for y.

Verification (H 8/2/3/1 = 14, V 4/1/2/1 = 8, polarities 0, pix_en=1 unless stated)
REQ-037 SHALL cover: reset, then 14 cycles -> x 0..13 then 0; y=1 after the wrap; hsync=0 for exactly the 3 cycles after x=10,11,12 were presented.
REQ-038 SHALL cover: run 112 cycles -> one frame_irq set at the (0,0) wrap, frame_cnt=1, vsync low for lines 5-6, blank high for x>=8 or y>=4.
REQ-039 SHALL cover: pix_en toggling 1,0,1,0 -> x advances only on enabled cycles and all outputs hold when pix_en=0.
REQ-040 SHALL cover: line_cmp=3 -> line_irq sets as y becomes 3; irq_clr in the same cycle as a frame_irq set leaves frame_irq=1; irq_clr the next cycle clears it.
REQ-041 SHALL cover: rst asserted at x=11, y=5 -> the next cycle shows x=0, y=0, hsync=1, vsync=1, and both interrupts 0.
REQ-042 SHALL cover: build without VGA_TIMING_LINE_IRQ_EN and line_cmp=3 -> line_irq stays 0 for a full frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the VGA timing generator:
//   - default 1024x768 timing (active, front porch, sync, back porch per axis)
//   - sync polarity constants
//   - clog2_f: constant ceiling-log2 used to size the x/y counters
// No ports; imported by vga_timing_gen and vga_axis_counter.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Default horizontal timing, in pixels
  localparam int DEF_H_ACTIVE = 32'sd1024;
  localparam int DEF_H_FP     = 32'sd24;
  localparam int DEF_H_SYNC   = 32'sd136;
  localparam int DEF_H_BP     = 32'sd160;

  // Default vertical timing, in lines
  localparam int DEF_V_ACTIVE = 32'sd768;
  localparam int DEF_V_FP     = 32'sd3;
  localparam int DEF_V_SYNC   = 32'sd6;
  localparam int DEF_V_BP     = 32'sd29;

  // Sync polarity: the level driven while inside the sync segment
  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

  // Number of bits needed to hold the values 0 .. value-1
  function automatic int clog2_f(input int value);
    int v;
    int result;
    v      = value - 32'sd1;
    result = 32'sd0;
    while (v > 32'sd0) begin
      v      = v >> 1;
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a 0..TOTAL-1 wrap counter with enable, plus the range
// compares the timing generator needs.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset (count -> 0)
//   en        in   advance enable
//   cnt       out  current count (registered)
//   wrap      out  high when en=1 and the count is at TOTAL-1 (next edge -> 0)
//   in_seg    out  SEG_LO <= cnt < SEG_HI (the sync segment)
//   in_active out  cnt < ACTIVE (the visible region)
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL  = 32'sd14,
  parameter int W      = 32'sd4,
  parameter int SEG_LO = 32'sd10,
  parameter int SEG_HI = 32'sd13,
  parameter int ACTIVE = 32'sd8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         in_seg,
  output logic         in_active
);

  localparam logic [W-1:0] LAST_C   = W'(TOTAL - 32'sd1);
  localparam logic [W-1:0] SEG_LO_C = W'(SEG_LO);
  localparam logic [W-1:0] SEG_HI_C = W'(SEG_HI);
  localparam logic [W-1:0] ACTIVE_C = W'(ACTIVE);
  localparam logic [W-1:0] ONE_C    = W'(32'd1);

  logic [W-1:0] cnt_r;
  logic         wrap_s;
  logic         in_seg_s;
  logic         in_active_s;

  // Count register: wraps from TOTAL-1 back to 0, holds while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (en) begin
      if (cnt_r == LAST_C) begin
        cnt_r <= {W{1'b0}};
      end else begin
        cnt_r <= cnt_r + ONE_C;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Wrap pulse and region decodes from the current count
  always_comb begin
    wrap_s      = 1'b0;
    in_seg_s    = 1'b0;
    in_active_s = 1'b0;
    if (en && (cnt_r == LAST_C)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
    if ((cnt_r >= SEG_LO_C) && (cnt_r < SEG_HI_C)) begin
      in_seg_s = 1'b1;
    end else begin
      in_seg_s = 1'b0;
    end
    if (cnt_r < ACTIVE_C) begin
      in_active_s = 1'b1;
    end else begin
      in_active_s = 1'b0;
    end
  end

  assign cnt       = cnt_r;
  assign wrap      = wrap_s;
  assign in_seg    = in_seg_s;
  assign in_active = in_active_s;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator: x/y position counters, registered sync and
// blank, an 8-bit frame counter and sticky frame / line interrupts.
// Optional feature: define VGA_TIMING_LINE_IRQ_EN to enable the raster-line
// compare interrupt (line_cmp / line_irq). Without it line_cmp is ignored and
// line_irq is tied to 0.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   pix_en     in   pixel-advance enable; all state holds while low
//   irq_clr    in   clears frame_irq and line_irq (a same-cycle set wins)
//   line_cmp   in   [YW] raster line that raises line_irq
//   x, y       out  [XW]/[YW] current position counters
//   hsync      out  registered horizontal sync (level HS_POL inside sync)
//   vsync      out  registered vertical sync (level VS_POL inside sync)
//   blank      out  registered blanking, 1 outside the visible area
//   frame_irq  out  sticky, set when the raster wraps to (0,0)
//   line_irq   out  sticky, set when a new line equal to line_cmp starts
//   frame_cnt  out  [8] frame counter, mod 256
// hsync/vsync/blank describe the x/y that was current one enabled cycle ago.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = POL_ACTIVE_LOW,
  parameter logic VS_POL   = POL_ACTIVE_LOW,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW       = clog2_f(H_TOTAL),
  localparam int  YW       = clog2_f(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          irq_clr,
  input  logic [YW-1:0] line_cmp,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          frame_irq,
  output logic          line_irq,
  output logic [7:0]    frame_cnt
);

  // Every timing segment must be at least one pixel / line long
  if ((H_ACTIVE <= 32'sd0) || (H_FP <= 32'sd0) || (H_SYNC <= 32'sd0) || (H_BP <= 32'sd0) ||
      (V_ACTIVE <= 32'sd0) || (V_FP <= 32'sd0) || (V_SYNC <= 32'sd0) || (V_BP <= 32'sd0))
  begin : g_param_err
    $error("vga_timing_gen: every timing segment parameter must be non-zero");
  end

  logic [XW-1:0] x_cnt_s;
  logic [YW-1:0] y_cnt_s;
  logic          x_wrap_s;
  logic          y_wrap_s;
  logic          x_sync_s;
  logic          y_sync_s;
  logic          x_act_s;
  logic          y_act_s;
  logic          frame_wrap_s;

  logic          hsync_r;
  logic          vsync_r;
  logic          blank_r;
  logic          frame_irq_r;
  logic [7:0]    frame_cnt_r;

  vga_axis_counter #(
    .TOTAL  (H_TOTAL),
    .W      (XW),
    .SEG_LO (H_ACTIVE + H_FP),
    .SEG_HI (H_ACTIVE + H_FP + H_SYNC),
    .ACTIVE (H_ACTIVE)
  ) u_x_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (pix_en),
    .cnt       (x_cnt_s),
    .wrap      (x_wrap_s),
    .in_seg    (x_sync_s),
    .in_active (x_act_s)
  );

  // y only steps when the line ends, so its enable is the x wrap pulse
  vga_axis_counter #(
    .TOTAL  (V_TOTAL),
    .W      (YW),
    .SEG_LO (V_ACTIVE + V_FP),
    .SEG_HI (V_ACTIVE + V_FP + V_SYNC),
    .ACTIVE (V_ACTIVE)
  ) u_y_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (x_wrap_s),
    .cnt       (y_cnt_s),
    .wrap      (y_wrap_s),
    .in_seg    (y_sync_s),
    .in_active (y_act_s)
  );

  // y_wrap already implies an enabled x wrap, so this is the (0,0) edge
  assign frame_wrap_s = y_wrap_s;

  // Sync/blank pipeline, frame counter and sticky frame interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_r     <= ~HS_POL;
      vsync_r     <= ~VS_POL;
      blank_r     <= 1'b0;
      frame_cnt_r <= 8'd0;
      frame_irq_r <= 1'b0;
    end else begin
      if (pix_en) begin
        hsync_r <= x_sync_s ? HS_POL : ~HS_POL;
        vsync_r <= y_sync_s ? VS_POL : ~VS_POL;
        blank_r <= ~(x_act_s & y_act_s);
      end else begin
        hsync_r <= hsync_r;
        vsync_r <= vsync_r;
        blank_r <= blank_r;
      end
      if (frame_wrap_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      // Set has priority over a clear arriving in the same cycle
      if (frame_wrap_s) begin
        frame_irq_r <= 1'b1;
      end else if (irq_clr) begin
        frame_irq_r <= 1'b0;
      end else begin
        frame_irq_r <= frame_irq_r;
      end
    end
  end

`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [YW-1:0] y_next_s;
  logic          line_hit_s;
  logic          line_irq_r;

  // Line about to start and whether it matches line_cmp; line_cmp only
  // matters at the x wrap, so a mid-line change lands at the next boundary
  always_comb begin
    y_next_s   = {YW{1'b0}};
    line_hit_s = 1'b0;
    if (y_wrap_s) begin
      y_next_s = {YW{1'b0}};
    end else begin
      y_next_s = y_cnt_s + YW'(32'd1);
    end
    if (x_wrap_s && (line_cmp == y_next_s) && (32'(line_cmp) < 32'(V_TOTAL))) begin
      line_hit_s = 1'b1;
    end else begin
      line_hit_s = 1'b0;
    end
  end

  // Sticky line interrupt; set wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      line_irq_r <= 1'b0;
    end else if (line_hit_s) begin
      line_irq_r <= 1'b1;
    end else if (irq_clr) begin
      line_irq_r <= 1'b0;
    end else begin
      line_irq_r <= line_irq_r;
    end
  end

  assign line_irq = line_irq_r;
`else
  logic unused_line_cmp_s;
  assign unused_line_cmp_s = ^line_cmp;
  assign line_irq          = 1'b0;
`endif

  assign x         = x_cnt_s;
  assign y         = y_cnt_s;
  assign hsync     = hsync_r;
  assign vsync     = vsync_r;
  assign blank     = blank_r;
  assign frame_irq = frame_irq_r;
  assign frame_cnt = frame_cnt_r;

endmodule
